// File: rtl/cache_line_refill_engine.sv
// Cache line refill engine: optional dirty-victim writeback, then a 16-word line fetch streamed to the data array.
// Optional macro CACHE_REFILL_CRITICAL_WORD_FIRST_EN starts the line fetch at the missed word and wraps mod 16.
module cache_line_refill_engine #(
  parameter int         WORDS_PER_LINE  = 16,
  parameter int         MAX_OUTSTANDING = 4,
  parameter logic [3:0] OPAQUE_HI       = 4'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          refill_val,
  output logic          refill_rdy,
  input  logic [25:0]   refill_line_addr,
  input  logic [3:0]    refill_word_off,
  input  logic          evict_en,
  input  logic [25:0]   evict_line_addr,
  input  logic [511:0]  evict_data,
  output logic          memreq_val,
  input  logic          memreq_rdy,
  output logic [76:0]   memreq_msg,
  input  logic          memresp_val,
  output logic          memresp_rdy,
  input  logic [44:0]   memresp_msg,
  output logic          fill_wen,
  output logic [3:0]    fill_word_idx,
  output logic [31:0]   fill_data,
  output logic          refill_done,
  output logic          refill_busy,
  output logic          proto_err
);

  localparam logic [4:0] LINE_WORDS = 5'(WORDS_PER_LINE);
  localparam logic [4:0] MAX_OUT    = 5'(MAX_OUTSTANDING);
  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;

  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_REFILL, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [4:0]   issued_q, issued_d, received_q, received_d;
  logic         proto_err_q, proto_err_d;
  logic         fill_wen_q, fill_wen_d;
  logic [3:0]   fill_idx_q, fill_idx_d;
  logic [31:0]  fill_data_q;
  logic [25:0]  line_addr_q, evict_addr_q;
  logic [511:0] evict_data_q;

  logic         cmd_fire, req_fire, resp_fire, in_xfer;
  logic [3:0]   word_base, req_idx, exp_idx;
  logic [2:0]   cur_type;
  logic [25:0]  cur_line;
  logic [31:0]  req_data;
  logic [2:0]   resp_type;
  logic [7:0]   resp_opaque;
  logic [31:0]  resp_data;
  logic         unused_resp_bits;

  assign cmd_fire  = refill_val && refill_rdy;
  assign req_fire  = memreq_val && memreq_rdy;
  assign resp_fire = memresp_val && memresp_rdy;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic [3:0] word_off_q;
  always_ff @(posedge clk) begin
    if (cmd_fire) word_off_q <= refill_word_off;
  end
  assign word_base = (state_q == S_REFILL) ? word_off_q : 4'h0;
`else
  logic unused_word_off;
  assign unused_word_off = ^refill_word_off;
  assign word_base       = 4'h0;
`endif

  // Response layout: type_[44:42], opaque[41:34], test/len[33:32], data[31:0].
  assign resp_type        = memresp_msg[44:42];
  assign resp_opaque      = memresp_msg[41:34];
  assign resp_data        = memresp_msg[31:0];
  assign unused_resp_bits = ^{memresp_msg[33:32], resp_opaque[7:4]};

  assign in_xfer  = (state_q == S_EVICT) || (state_q == S_REFILL);
  assign req_idx  = issued_q[3:0] + word_base;
  assign exp_idx  = received_q[3:0] + word_base;
  assign cur_type = (state_q == S_EVICT) ? TYPE_WRITE : TYPE_READ;
  assign cur_line = (state_q == S_EVICT) ? evict_addr_q : line_addr_q;
  assign req_data = (state_q == S_EVICT) ? evict_data_q[{req_idx, 5'd0} +: 32] : 32'd0;

  // The message is a pure function of held state, so it cannot change while a request stalls.
  assign memreq_msg = {cur_type, OPAQUE_HI, req_idx, cur_line, req_idx, 2'b00, 2'b00, req_data};
  assign memreq_val = in_xfer && (issued_q < LINE_WORDS) && ((issued_q - received_q) < MAX_OUT);

  // Responses outside EVICT/REFILL are accepted and dropped so memory can never wedge.
  assign memresp_rdy = 1'b1;
  assign refill_rdy  = (state_q == S_IDLE);
  assign refill_busy = (state_q != S_IDLE);
  assign refill_done = (state_q == S_DONE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    issued_d    = issued_q;
    received_d  = received_q;
    proto_err_d = proto_err_q;
    fill_wen_d  = 1'b0;
    fill_idx_d  = fill_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d    = evict_en ? S_EVICT : S_REFILL;
          issued_d   = '0;
          received_d = '0;
        end
      end
      S_EVICT, S_REFILL: begin
        if (req_fire) issued_d = issued_q + 5'd1;
        if (resp_fire) begin
          received_d = received_q + 5'd1;
          if ((resp_type != cur_type) || (resp_opaque[3:0] != exp_idx)) proto_err_d = 1'b1;
          if (state_q == S_REFILL) begin
            fill_wen_d = 1'b1;
            fill_idx_d = exp_idx;
          end
          if (received_q == LINE_WORDS - 5'd1) begin
            state_d    = (state_q == S_EVICT) ? S_REFILL : S_DONE;
            issued_d   = '0;
            received_d = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      received_q  <= '0;
      proto_err_q <= 1'b0;
      fill_wen_q  <= 1'b0;
      fill_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      proto_err_q <= proto_err_d;
      fill_wen_q  <= fill_wen_d;
      fill_idx_q  <= fill_idx_d;
    end
  end

  // NOTE: wide payload registers are left unreset; they are only consumed under qualified controls.
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      line_addr_q  <= refill_line_addr;
      evict_addr_q <= evict_line_addr;
      evict_data_q <= evict_data;
    end
    if (resp_fire && (state_q == S_REFILL)) fill_data_q <= resp_data;
  end

  assign fill_wen      = fill_wen_q;
  assign fill_word_idx = fill_idx_q;
  assign fill_data     = fill_data_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_cache_line_refill_engine.sv
// Scoreboard bench for cache_line_refill_engine: expected requests/fills are queued at command time
// and popped as the DUT issues them; an in-order memory model answers every request.
module tb_cache_line_refill_engine;

  localparam int MAX_OUT = 4;

  logic         clk, reset;
  logic         refill_val, refill_rdy;
  logic [25:0]  refill_line_addr, evict_line_addr;
  logic [3:0]   refill_word_off;
  logic         evict_en;
  logic [511:0] evict_data;
  logic         memreq_val, memreq_rdy;
  logic [76:0]  memreq_msg;
  logic         memresp_val, memresp_rdy;
  logic [44:0]  memresp_msg;
  logic         fill_wen;
  logic [3:0]   fill_word_idx;
  logic [31:0]  fill_data;
  logic         refill_done, refill_busy, proto_err;

  cache_line_refill_engine #(.WORDS_PER_LINE(16), .MAX_OUTSTANDING(MAX_OUT), .OPAQUE_HI(4'h0)) dut (
    .clk(clk), .reset(reset),
    .refill_val(refill_val), .refill_rdy(refill_rdy),
    .refill_line_addr(refill_line_addr), .refill_word_off(refill_word_off),
    .evict_en(evict_en), .evict_line_addr(evict_line_addr), .evict_data(evict_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .fill_wen(fill_wen), .fill_word_idx(fill_word_idx), .fill_data(fill_data),
    .refill_done(refill_done), .refill_busy(refill_busy), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [76:0] act, input logic [76:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [76:0] exp_req_q[$];
  logic [35:0] exp_fill_q[$];
  logic [44:0] mem_q[$];
  int          done_cnt = 0, start_done = 0, outstanding = 0, rd_resp_cnt = 0, corrupt_word = -1;
  bit          hold_resp = 0, rdy_random = 0, stray_mode = 0, prev_stall = 0;
  logic [76:0] prev_msg;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [3:0] first_word(input logic [3:0] off);
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    return off;
`else
    return 4'h0;
`endif
  endfunction

  // Memory model + output monitor: inputs driven at negedge, handshakes judged 1 time unit later.
  initial begin : mem_model
    logic [76:0] req;
    logic [35:0] ef;
    logic [44:0] resp;
    logic [7:0]  opq;
    bit          from_mem;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    memresp_msg = '0;
    forever begin
      @(negedge clk);
      if (fill_wen) begin
        check("fill_after_read_resp", 77'(rd_resp_cnt > 0), 77'd1);
        if (exp_fill_q.size() == 0) check("fill_unexpected", 77'(fill_wen), 77'd0);
        else begin
          ef = exp_fill_q.pop_front();
          check("fill_idx", 77'(fill_word_idx), 77'(ef[35:32]));
          check("fill_data", 77'(fill_data), 77'(ef[31:0]));
        end
      end
      if (refill_done) begin
        done_cnt++;
        check("done_with_last_fill", 77'(exp_fill_q.size()), 77'd0);
      end
      if (prev_stall) begin
        check("stall_req_val_held", 77'(memreq_val), 77'd1);
        check("stall_req_msg_held", memreq_msg, prev_msg);
      end
      memreq_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      from_mem   = (mem_q.size() > 0) && !hold_resp;
      if (from_mem) begin
        memresp_val = 1'b1;
        memresp_msg = mem_q[0];
      end else if (stray_mode) begin
        memresp_val = 1'b1;
        memresp_msg = {3'($urandom_range(0, 1)), 8'($urandom), 2'b00, 32'($urandom)};
      end else begin
        memresp_val = 1'b0;
      end
      #1;
      if (memreq_val && memreq_rdy) begin
        req = memreq_msg;
        if (exp_req_q.size() == 0) check("req_unexpected", 77'(memreq_val), 77'd0);
        else check("req_msg", req, exp_req_q.pop_front());
        outstanding++;
        check("outstanding_le_max", 77'(outstanding <= MAX_OUT), 77'd1);
        opq = req[73:66];
        if (req[76:74] == 3'd0) begin
          if (corrupt_word >= 0 && opq[3:0] == 4'(corrupt_word)) opq = 8'h07;
          resp = {3'd0, opq, 2'b00, mem_rd(req[65:34])};
        end else begin
          resp = {3'd1, opq, 2'b00, 32'd0};
        end
        mem_q.push_back(resp);
      end
      prev_stall = memreq_val && !memreq_rdy;
      prev_msg   = memreq_msg;
      if (memresp_val && memresp_rdy && from_mem) begin
        resp = mem_q.pop_front();
        outstanding--;
        if (resp[44:42] == 3'd0) rd_resp_cnt++;
      end
    end
  end

  task automatic start_refill(input logic [25:0] line, input logic [3:0] off, input bit evict,
                              input logic [25:0] vline, input logic [511:0] vdata, input int hold);
    logic [3:0]  idx;
    logic [31:0] a;
    if (evict) begin
      for (int i = 0; i < 16; i++) begin
        idx = 4'(i);
        exp_req_q.push_back({3'd1, 4'h0, idx, vline, idx, 2'b00, 2'b00, vdata[32*i +: 32]});
      end
    end
    for (int i = 0; i < 16; i++) begin
      idx = first_word(off) + 4'(i);
      a   = {line, idx, 2'b00};
      exp_req_q.push_back({3'd0, 4'h0, idx, a, 2'b00, 32'd0});
      exp_fill_q.push_back({idx, mem_rd(a)});
    end
    rd_resp_cnt = 0;
    start_done  = done_cnt;
    @(negedge clk);
    check("rdy_before_cmd", 77'(refill_rdy), 77'd1);
    refill_val       = 1'b1;
    refill_line_addr = line;
    refill_word_off  = off;
    evict_en         = evict;
    evict_line_addr  = vline;
    evict_data       = vdata;
    @(negedge clk);
    evict_data       = ~vdata;
    refill_line_addr = ~line;
    repeat (hold) begin
      check("rdy_while_busy", 77'(refill_rdy), 77'd0);
      @(negedge clk);
    end
    refill_val = 1'b0;
  endtask

  task automatic finish_refill(input bit exp_perr);
    int budget = 0;
    while (done_cnt == start_done && budget < 600) begin
      @(negedge clk);
      #2;
      budget++;
    end
    check("done_timeout", 77'(done_cnt != start_done), 77'd1);
    repeat (3) @(negedge clk);
    #2;
    check("done_once", 77'(done_cnt - start_done), 77'd1);
    check("req_queue_empty", 77'(exp_req_q.size()), 77'd0);
    check("fill_queue_empty", 77'(exp_fill_q.size()), 77'd0);
    check("proto_err", 77'(proto_err), 77'(exp_perr));
    check("idle_busy", 77'(refill_busy), 77'd0);
    check("idle_rdy", 77'(refill_rdy), 77'd1);
  endtask

  initial begin : main
    logic [511:0] vdata;
    int           budget;
    reset            = 1'b0;
    refill_val       = 1'b0;
    refill_line_addr = '0;
    refill_word_off  = '0;
    evict_en         = 1'b0;
    evict_line_addr  = '0;
    evict_data       = '0;
    #13;
    check("rst_refill_rdy", 77'(refill_rdy), 77'd1);
    check("rst_memreq_val", 77'(memreq_val), 77'd0);
    check("rst_fill_wen", 77'(fill_wen), 77'd0);
    check("rst_refill_done", 77'(refill_done), 77'd0);
    check("rst_refill_busy", 77'(refill_busy), 77'd0);
    check("rst_proto_err", 77'(proto_err), 77'd0);
    @(negedge clk);
    reset = 1'b1;

    // Clean miss to line 0x40: reads 0x1000..0x103C.
    start_refill(26'h0000040, 4'h0, 1'b0, 26'h0, '0, 0);
    finish_refill(1'b0);

    // Dirty miss with random request back-pressure; refill_val held while busy.
    for (int i = 0; i < 16; i++) vdata[32*i +: 32] = 32'hA000 + 32'(i);
    rdy_random = 1'b1;
    start_refill(26'h0000002, 4'h0, 1'b1, 26'h0000001, vdata, 4);
    finish_refill(1'b0);
    rdy_random = 1'b0;

    // Responses withheld: outstanding must saturate at MAX_OUT.
    hold_resp = 1'b1;
    start_refill(26'h0000080, 4'h0, 1'b0, 26'h0, '0, 0);
    repeat (12) @(negedge clk);
    #2;
    check("stall_outstanding", 77'(outstanding), 77'(MAX_OUT));
    check("stall_memreq_val", 77'(memreq_val), 77'd0);
    check("stall_busy", 77'(refill_busy), 77'd1);
    hold_resp = 1'b0;
    finish_refill(1'b0);

    // Bad opaque on word 5: sticky error, word still written at idx 5.
    corrupt_word = 5;
    start_refill(26'h0000123, 4'h0, 1'b0, 26'h0, '0, 0);
    finish_refill(1'b1);
    corrupt_word = -1;
    start_refill(26'h0000124, 4'hE, 1'b0, 26'h0, '0, 0);
    finish_refill(1'b1);

    // Reset mid-REFILL after 7 read responses.
    start_refill(26'h0000055, 4'h0, 1'b0, 26'h0, '0, 0);
    budget = 0;
    while (rd_resp_cnt < 7 && budget < 200) begin
      @(negedge clk);
      #2;
      budget++;
    end
    check("reach_7_resps", 77'(rd_resp_cnt >= 7), 77'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_memreq_val", 77'(memreq_val), 77'd0);
    check("abort_fill_wen", 77'(fill_wen), 77'd0);
    check("abort_done", 77'(refill_done), 77'd0);
    check("abort_busy", 77'(refill_busy), 77'd0);
    check("abort_rdy", 77'(refill_rdy), 77'd1);
    check("abort_proto_err", 77'(proto_err), 77'd0);
    exp_req_q.delete();
    exp_fill_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    stray_mode = 1'b1;
    budget = 0;
    while (mem_q.size() > 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (6) @(negedge clk);
    stray_mode  = 1'b0;
    outstanding = 0;
    #2;
    check("stray_drained", 77'(mem_q.size()), 77'd0);
    check("stray_busy", 77'(refill_busy), 77'd0);
    check("stray_proto_err", 77'(proto_err), 77'd0);
    check("stray_done_cnt", 77'(done_cnt - start_done), 77'd0);
    start_refill(26'h3FFFFFF, 4'hE, 1'b0, 26'h0, '0, 0);
    finish_refill(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_line_refill_engine.md
Name: cache_line_refill_engine

Overview:
- Memory-side stage directly downstream of the cache datapath/control.
- On a miss, accepts one refill command, optionally writes back a 512-bit dirty victim line, then fetches the 16-word line one 4B word at a time.
- Streams each returned word, with its word index, to the data-array write port, then pulses done.
- Memory side uses the team's 77-bit mem_req_4B_t and 45-bit mem_resp_4B_t packed formats with val/rdy handshakes.

Parameters:
- WORDS_PER_LINE, 16, words per cache line; the design is fixed at 16 and index fields are 4 bits.
- MAX_OUTSTANDING, 4, maximum memory requests in flight (1..16).
- OPAQUE_HI, 4'h0, value driven on opaque[7:4] of every request.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- refill_val  in  1  refill command valid
- refill_rdy  out  1  engine idle, can accept a command
- refill_line_addr  in  26  line address of the miss (addr[31:6])
- refill_word_off  in  4  missed word offset; used only under the optional feature
- evict_en  in  1  victim is dirty, write it back first
- evict_line_addr  in  26  victim line address
- evict_data  in  512  victim line; word i is bits [32i+31:32i]
- memreq_val  out  1  request to memory valid
- memreq_rdy  in  1  memory accepts request
- memreq_msg  out  77  {type_, opaque, addr, len, data}
- memresp_val  in  1  memory response valid
- memresp_rdy  out  1  engine accepts response
- memresp_msg  in  45  {type_, opaque, test, len, data}
- fill_wen  out  1  write one word into the data array
- fill_word_idx  out  4  word index within the line
- fill_data  out  32  word to write
- refill_done  out  1  one-cycle completion pulse
- refill_busy  out  1  engine is not IDLE
- proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all counters 0; memreq_val, fill_wen, refill_done, proto_err, refill_busy all 0; refill_rdy 1.
- States: IDLE, EVICT, REFILL, DONE.
- IDLE:
  - refill_rdy=1.
  - On refill_val&&refill_rdy, capture all command inputs (evict_data held in a 512-bit register).
  - Next state is EVICT if evict_en, else REFILL.
  - memresp_rdy=1; stray responses are discarded with no side effects.
- Request format:
  - type_: WRITE=1 in EVICT, READ=0 in REFILL.
  - opaque={OPAQUE_HI, word_idx}.
  - addr={line_addr, word_idx, 2'b00}.
  - len=0.
  - data=evict word word_idx in EVICT, 0 in REFILL.
- Issue/receive counters (5-bit each, cleared on entry to EVICT and REFILL):
  - memreq_val = (issued<16) && ((issued-received)<MAX_OUTSTANDING).
  - issued increments on memreq handshake; received increments on memresp handshake.
  - Both may increment in the same cycle.
  - memreq_msg stays stable while memreq_val && !memreq_rdy.
- Responses:
  - memresp_rdy=1 in EVICT and REFILL.
  - Responses arrive in order; expected word index = received[3:0].
- EVICT: when the 16th write ack is accepted, go to REFILL next cycle.
- REFILL:
  - A response handshake in cycle N gives fill_wen=1 in cycle N+1, with fill_word_idx=expected index and fill_data=resp.data (registered).
  - When the 16th response is accepted in cycle N, state is DONE in N+1. refill_done=1 and the last fill_wen are both in N+1.
  - State is IDLE in N+2.
- DONE: one cycle; memreq_val=0.
- proto_err is set when an accepted response has a type_ mismatch (ack type != request type) or opaque[3:0] != expected index.
  - The word is still written at the expected index.
  - proto_err is cleared only by reset.
- Reset mid-operation aborts immediately with no done pulse; responses arriving later are discarded in IDLE.
- refill_val while busy is ignored because refill_rdy=0.

Optional Feature:
- Macro: CACHE_REFILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - REFILL read requests and expected indices start at refill_word_off and wrap modulo 16, i.e. word_idx = (refill_word_off + count) mod 16.
  - The first fill_wen carries the missed word.
  - EVICT order is unchanged (0..15).
- Undefined: refill_word_off is ignored; REFILL order is 0..15.

Test Plan:
- Clean miss (evict_en=0), line 0x0000040, memreq_rdy=1, memresp returns next cycle -> 16 READs to addr 0x1000..0x103C with opaque 0x00..0x0F; fill_idx 0..15; one refill_done; proto_err=0.
- Dirty miss, victim line 0x0000001 with data word i=0xA000+i -> 16 WRITEs to 0x40..0x7C carrying those data values, then 16 READs; no fill_wen before the first READ response.
- Memory stalls responses, memreq_rdy=1 -> exactly MAX_OUTSTANDING=4 requests outstanding; memreq_val deasserts until a response is accepted; memreq_msg stable during memreq_rdy=0 stalls.
- Response 5 returns opaque 0x07 -> proto_err=1 and stays 1 through the next refill; word 5 still written at idx 5.
- Drop reset mid-REFILL after 7 responses -> outputs immediately at reset values; release; stray responses are ignored; a new refill completes normally.
- With the macro defined, refill_word_off=0xE -> READ order 14,15,0..13; first fill_idx=14.
